// File: rtl/signed_multiplier_sequencer_if.sv
// Start/done handshake and operand/product bus for the signed multiply engine.
// The master drives the request; the slave (the sequencer) returns the product.
interface signed_multiplier_sequencer_if #(
   parameter int unsigned INBits = 16
);
   logic                  start;
   logic [INBits-1:0]     Multiplicand;
   logic [INBits-1:0]     Multiplier;
   logic [2*INBits-1:0]   Result;
   logic                  Sign;
   logic                  done;
   logic                  busy;

   modport master (
      output start, Multiplicand, Multiplier,
      input  Result, Sign, done, busy
   );

   modport slave (
      input  start, Multiplicand, Multiplier,
      output Result, Sign, done, busy
   );
endinterface

// File: rtl/signed_multiplier_sequencer.sv
// Signed multiply engine: sign/magnitude conversion, INBits-cycle unsigned
// shift-add over the magnitudes, then re-application of the product sign.
module signed_multiplier_sequencer #(
   parameter int unsigned INBits = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   signed_multiplier_sequencer_if.slave bus
);
   localparam int unsigned W     = INBits;
   localparam int unsigned PW    = 2 * INBits;
   localparam int unsigned CNT_W = $clog2(INBits + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_MULT = 2'd2,
      ST_SIGN = 2'd3
   } state_t;

   state_t           r_state, w_state;
   logic [W-1:0]     r_a, w_a;
   logic [W-1:0]     r_b, w_b;
   logic [PW-1:0]    r_mcand, w_mcand;
   logic [W-1:0]     r_mplier, w_mplier;
   logic [PW-1:0]    r_acc, w_acc;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_prod_sign, w_prod_sign;
   logic [PW-1:0]    r_result, w_result;
   logic             r_sign, w_sign;
   logic             r_done, w_done;
   logic             r_busy, w_busy;

   logic [W-1:0]     w_mag_a;
   logic [W-1:0]     w_mag_b;

   // The most-negative operand maps to 100..0, which reads correctly as unsigned.
   assign w_mag_a = r_a[W-1] ? (~r_a + W'(1)) : r_a;
   assign w_mag_b = r_b[W-1] ? (~r_b + W'(1)) : r_b;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_prod_sign <= 1'b0;
         r_result    <= '0;
         r_sign      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_a         <= w_a;
         r_b         <= w_b;
         r_mcand     <= w_mcand;
         r_mplier    <= w_mplier;
         r_acc       <= w_acc;
         r_cnt       <= w_cnt;
         r_prod_sign <= w_prod_sign;
         r_result    <= w_result;
         r_sign      <= w_sign;
         r_done      <= w_done;
         r_busy      <= w_busy;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_a         = r_a;
      w_b         = r_b;
      w_mcand     = r_mcand;
      w_mplier    = r_mplier;
      w_acc       = r_acc;
      w_cnt       = r_cnt;
      w_prod_sign = r_prod_sign;
      w_result    = r_result;
      w_sign      = r_sign;
      w_done      = 1'b0;
      w_busy      = r_busy;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_a     = bus.Multiplicand;
               w_b     = bus.Multiplier;
               w_busy  = 1'b1;
               w_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_mcand     = PW'(w_mag_a);
            w_mplier    = w_mag_b;
            w_acc       = '0;
            w_cnt       = '0;
            w_prod_sign = r_a[W-1] ^ r_b[W-1];
            w_state     = ST_MULT;
         end
         ST_MULT: begin
            if (r_mplier[0]) begin
               w_acc = r_acc + r_mcand;
            end
            w_mcand  = r_mcand << 1;
            w_mplier = r_mplier >> 1;
            w_cnt    = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(W - 1)) begin
               w_state = ST_SIGN;
            end
         end
         ST_SIGN: begin
            // A zero product is always reported as positive.
            if (r_prod_sign && (r_acc != '0)) begin
               w_result = ~r_acc + PW'(1);
               w_sign   = 1'b1;
            end else begin
               w_result = r_acc;
               w_sign   = 1'b0;
            end
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
   end

   assign bus.Result = r_result;
   assign bus.Sign   = r_sign;
   assign bus.done   = r_done;
   assign bus.busy   = r_busy;

endmodule

// File: tb/tb_signed_multiplier_sequencer.sv
// Directed bench for signed_multiplier_sequencer at INBits=8: latency, signs,
// extremes, zero product, ignored starts, back-to-back and async reset.
module tb_signed_multiplier_sequencer;
   localparam int unsigned INBits = 8;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   n;

   signed_multiplier_sequencer_if #(.INBits(INBits)) bus ();

   signed_multiplier_sequencer #(.INBits(INBits)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one start pulse and verify latency, busy, result and sign.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_res, input logic exp_sign);
      int k;
      bus.Multiplicand = a;
      bus.Multiplier   = b;
      bus.start        = 1'b1;
      tick();
      bus.start        = 1'b0;
      bus.Multiplicand = 8'hAA;
      bus.Multiplier   = 8'h55;
      k = 0;
      while (!bus.done && k < 20) begin
         check({tag, "_busy"}, 32'(bus.busy), 32'd1);
         tick();
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'd10);
      check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      check({tag, "_result"}, 32'(bus.Result), 32'(exp_res));
      check({tag, "_sign"}, 32'(bus.Sign), 32'(exp_sign));
      tick();
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_result_hold"}, 32'(bus.Result), 32'(exp_res));
   endtask

   initial begin
      errors           = 0;
      checks           = 0;
      reset            = 1'b0;
      bus.start        = 1'b0;
      bus.Multiplicand = '0;
      bus.Multiplier   = '0;

      #12;
      check("rst_result", 32'(bus.Result), 32'd0);
      check("rst_sign",   32'(bus.Sign),   32'd0);
      check("rst_done",   32'(bus.done),   32'd0);
      check("rst_busy",   32'(bus.busy),   32'd0);
      tick();
      reset = 1'b1;
      tick();

      run_op("pp_3x5",     8'd3,    8'd5,    16'h000F, 1'b0);
      run_op("np_m3x5",    8'hFD,   8'd5,    16'hFFF1, 1'b1);
      run_op("pn_5xm3",    8'd5,    8'hFD,   16'hFFF1, 1'b1);
      run_op("nn_m7xm9",   8'hF9,   8'hF7,   16'h003F, 1'b0);
      run_op("ext_m128sq", 8'h80,   8'h80,   16'h4000, 1'b0);
      run_op("ext_m128x127", 8'h80, 8'h7F,   16'hC080, 1'b1);
      run_op("ext_127sq",  8'h7F,   8'h7F,   16'h3F01, 1'b0);
      run_op("zero_0xm7",  8'h00,   8'hF9,   16'h0000, 1'b0);

      // Starts with new operands mid-operation must be ignored.
      bus.Multiplicand = 8'd3;
      bus.Multiplier   = 8'd5;
      bus.start        = 1'b1;
      tick();
      n = 0;
      while (!bus.done && n < 20) begin
         if (n == 2 || n == 8) begin
            bus.start        = 1'b1;
            bus.Multiplicand = 8'd100;
            bus.Multiplier   = 8'd100;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      check("ign_latency", 32'(n), 32'd10);
      check("ign_result",  32'(bus.Result), 32'h000F);
      check("ign_sign",    32'(bus.Sign),   32'd0);
      tick();
      check("ign_no_restart", 32'(bus.busy), 32'd0);
      tick();

      // Start held high through done: second op accepted on the next edge.
      bus.Multiplicand = 8'd2;
      bus.Multiplier   = 8'd3;
      bus.start        = 1'b1;
      tick();
      n = 0;
      while (!bus.done && n < 20) begin
         tick();
         n++;
      end
      check("b2b_first_latency", 32'(n), 32'd10);
      check("b2b_first_result",  32'(bus.Result), 32'h0006);
      bus.Multiplicand = 8'hFE;
      bus.Multiplier   = 8'd3;
      tick();
      bus.start = 1'b0;
      check("b2b_busy_again", 32'(bus.busy), 32'd1);
      n = 1;
      while (!bus.done && n < 30) begin
         tick();
         n++;
      end
      check("b2b_spacing",       32'(n), 32'd11);
      check("b2b_second_result", 32'(bus.Result), 32'hFFFA);
      check("b2b_second_sign",   32'(bus.Sign),   32'd1);
      tick();

      // Asynchronous reset during the fourth MULT iteration.
      bus.Multiplicand = 8'd7;
      bus.Multiplier   = 8'd9;
      bus.start        = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_result", 32'(bus.Result), 32'd0);
      check("arst_sign",   32'(bus.Sign),   32'd0);
      check("arst_done",   32'(bus.done),   32'd0);
      check("arst_busy",   32'(bus.busy),   32'd0);
      tick();
      reset = 1'b1;
      tick();
      run_op("post_rst_3x5", 8'd3, 8'd5, 16'h000F, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
